// File: rtl/ddram_arb_pkg.sv
// rtl/ddram_arb_pkg.sv - shared types and constants for the DDRAM burst arbiter
package ddram_arb_pkg;

  localparam int DDR_BE_W    = 8;
  localparam int NUM_PORTS   = 2;
  localparam int CMD_ADDR_W  = 29;
  localparam int CMD_BURST_W = 8;

  typedef enum logic [1:0] {IDLE, WRITE, RD_CMD, RD_WAIT} arb_state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0]  addr;
    logic [CMD_BURST_W-1:0] burstcnt;
    logic [DDR_BE_W-1:0]    be;
    logic                   we;
  } burst_cmd_t;

  // A zero-length request still moves one beat.
  function automatic logic [CMD_BURST_W-1:0] fix_burstcnt(input logic [CMD_BURST_W-1:0] bc);
    return (bc == '0) ? CMD_BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/ddram_rr_pick.sv
// rtl/ddram_rr_pick.sv - two-port round-robin select; pointer moves to the other port after a burst
module ddram_rr_pick (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic       valid,
  output logic       pick
);

  logic ptr;

  always_comb begin
    valid = |req;
    pick  = (&req) ? ptr : req[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= 1'b0;
    else if (advance)
      ptr <= ~owner;
  end

endmodule

// File: rtl/ddram_burst_arbiter.sv
// rtl/ddram_burst_arbiter.sv - two-requester burst arbiter/sequencer for the DDRAM port
// Optional saturating stall counter on busy_cycles: define DDRAM_ARB_BUSYCNT_EN.
module ddram_burst_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int ADDR_W  = CMD_ADDR_W,
  parameter int DATA_W  = 64,
  parameter int BURST_W = CMD_BURST_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*BURST_W-1:0]  burstcnt,
  input  logic [2*DDR_BE_W-1:0] be,
  input  logic [2*DATA_W-1:0]   wr_data,
  output logic [1:0]            gnt,
  output logic [1:0]            wr_next,
  output logic [DATA_W-1:0]     rd_data,
  output logic [1:0]            rd_valid,
  input  logic                  stop,
  output logic                  stopped,
  input  logic                  ddr_busy,
  output logic [BURST_W-1:0]    ddr_burstcnt,
  output logic [ADDR_W-1:0]     ddr_addr,
  output logic                  ddr_rd,
  output logic                  ddr_we,
  output logic [DATA_W-1:0]     ddr_din,
  output logic [DDR_BE_W-1:0]   ddr_be,
  input  logic [DATA_W-1:0]     ddr_dout,
  input  logic                  ddr_dout_ready,
  output logic [31:0]           busy_cycles
);

  arb_state_t         state;
  logic               owner;
  logic [BURST_W-1:0] beat_cnt;
  logic               pick_valid;
  logic               pick;
  logic               last_beat;
  logic               advance;
  burst_cmd_t         sel_cmd;

  ddram_rr_pick u_pick (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .owner   (owner),
    .valid   (pick_valid),
    .pick    (pick)
  );

  always_comb begin
    sel_cmd.addr     = CMD_ADDR_W'(pick ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0]);
    sel_cmd.burstcnt = fix_burstcnt(CMD_BURST_W'(pick ? burstcnt[2*BURST_W-1:BURST_W]
                                                      : burstcnt[BURST_W-1:0]));
    sel_cmd.be       = pick ? be[2*DDR_BE_W-1:DDR_BE_W] : be[DDR_BE_W-1:0];
    sel_cmd.we       = pick ? we[1] : we[0];

    last_beat = (beat_cnt == ddr_burstcnt - BURST_W'(1));
    advance   = last_beat & (((state == WRITE) & ~ddr_busy) |
                             ((state == RD_WAIT) & ddr_dout_ready));

    wr_next = '0;
    if (state == WRITE && !ddr_busy)
      wr_next[owner] = 1'b1;
    ddr_din = owner ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
    stopped = stop & (state == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      beat_cnt     <= '0;
      gnt          <= '0;
      rd_valid     <= '0;
      rd_data      <= '0;
      ddr_rd       <= 1'b0;
      ddr_we       <= 1'b0;
      ddr_addr     <= '0;
      ddr_burstcnt <= '0;
      ddr_be       <= '0;
    end else begin
      gnt      <= '0;
      rd_valid <= '0;
      case (state)
        IDLE: begin
          if (!stop && pick_valid) begin
            owner        <= pick;
            ddr_addr     <= ADDR_W'(sel_cmd.addr);
            ddr_burstcnt <= BURST_W'(sel_cmd.burstcnt);
            ddr_be       <= sel_cmd.be;
            beat_cnt     <= '0;
            gnt[pick]    <= 1'b1;
            if (sel_cmd.we) begin
              state  <= WRITE;
              ddr_we <= 1'b1;
            end else begin
              state  <= RD_CMD;
              ddr_rd <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (!ddr_busy) begin
            if (last_beat) begin
              ddr_we   <= 1'b0;
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BURST_W'(1);
            end
          end
        end
        RD_CMD: begin
          if (!ddr_busy) begin
            ddr_rd <= 1'b0;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (ddr_dout_ready) begin
            rd_data         <= ddr_dout;
            rd_valid[owner] <= 1'b1;
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BURST_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDRAM_ARB_BUSYCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_cycles <= '0;
    else if ((ddr_we | ddr_rd) & ddr_busy & (busy_cycles != 32'hFFFF_FFFF))
      busy_cycles <= busy_cycles + 32'd1;
  end
`else
  assign busy_cycles = '0;
`endif

endmodule
